// File: rtl/rename_regfile_ckpt_if.sv
// Bundle of dispatch-side signals for the renaming register file:
// writeback ports, read ports, rename request, branch checkpoint control.
interface rename_regfile_ckpt_if #(
    parameter int NAME_W     = 5,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int CKPT_DEPTH = 4,
    parameter int NWB        = 2,
    parameter int NRD        = 2
);
    localparam int CNT_W = $clog2(CKPT_DEPTH);

    logic                    rdy;
    logic [NWB-1:0]          wb_en;
    logic [NWB*TAG_W-1:0]    wb_tag;
    logic [NWB*DATA_W-1:0]   wb_data;
    logic [NRD*NAME_W-1:0]   rd_name;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic [NRD*TAG_W-1:0]    rd_tag;
    logic                    ren_en;
    logic [NAME_W-1:0]       ren_name;
    logic [TAG_W-1:0]        ren_tag;
    logic                    br_push;
    logic                    br_free;
    logic                    br_mis;
    logic [CNT_W-1:0]        ckpt_count;
    logic                    ckpt_full;
    logic                    ckpt_empty;

    modport master (
        output rdy, wb_en, wb_tag, wb_data, rd_name,
               ren_en, ren_name, ren_tag, br_push, br_free, br_mis,
        input  rd_data, rd_tag, ckpt_count, ckpt_full, ckpt_empty
    );

    modport slave (
        input  rdy, wb_en, wb_tag, wb_data, rd_name,
               ren_en, ren_name, ren_tag, br_push, br_free, br_mis,
        output rd_data, rd_tag, ckpt_count, ckpt_full, ckpt_empty
    );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// Renaming register file with a per-register ring of branch snapshots.
// Slots head..head+count are live; head+count is the active (current) view.
// Writebacks update every live slot; a mispredict collapses back to head.
module rename_regfile_ckpt #(
    parameter int NREG       = 32,
    parameter int NAME_W     = 5,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int CKPT_DEPTH = 4,
    parameter int NWB        = 2,
    parameter int NRD        = 2
) (
    input logic clk,
    input logic rst,
    rename_regfile_ckpt_if.slave bus
);
    localparam int CNT_W = $clog2(CKPT_DEPTH);
    localparam logic [TAG_W-1:0] TAG_FREE = '1;

    typedef logic [CNT_W-1:0] ptr_t;

    logic [TAG_W-1:0]  tag_q  [NREG][CKPT_DEPTH];
    logic [TAG_W-1:0]  tag_n  [NREG][CKPT_DEPTH];
    logic [DATA_W-1:0] data_q [NREG][CKPT_DEPTH];
    logic [DATA_W-1:0] data_n [NREG][CKPT_DEPTH];

    ptr_t head_q, count_q, head_n, count_n;
    ptr_t active, active_nxt, ren_slot;
    logic full_q, empty_q;
    logic push_ok, free_ok, ren_hit;
    logic [CKPT_DEPTH-1:0] live;

    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD*TAG_W-1:0]  rd_tag_c;

    // Apply this cycle's writebacks to one entry; ports are scanned high to
    // low so the lowest matching port ends up winning.
    function automatic logic [TAG_W+DATA_W-1:0] apply_wb(
        input logic [TAG_W-1:0]        t,
        input logic [DATA_W-1:0]       d,
        input logic [NWB-1:0]          en,
        input logic [NWB*TAG_W-1:0]    wtag,
        input logic [NWB*DATA_W-1:0]   wdata
    );
        logic [TAG_W+DATA_W-1:0] res;
        res = {t, d};
        for (int k = NWB - 1; k >= 0; k--) begin
            if (en[k] && (wtag[k*TAG_W +: TAG_W] != TAG_FREE) &&
                (wtag[k*TAG_W +: TAG_W] == t)) begin
                res = {TAG_FREE, wdata[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    // Pointer arithmetic, branch acceptance and live-slot mask.
    always_comb begin
        active     = head_q + count_q;
        active_nxt = active + ptr_t'(1);
        push_ok    = bus.br_push && (count_q != ptr_t'(CKPT_DEPTH - 1));
        free_ok    = bus.br_free && (count_q != '0);
        ren_hit    = bus.ren_en && (bus.ren_name != '0);
        ren_slot   = push_ok ? active_nxt : active;
        if (bus.br_mis) begin
            head_n  = head_q;
            count_n = '0;
        end else begin
            head_n  = head_q + ptr_t'(free_ok);
            count_n = count_q + ptr_t'(push_ok) - ptr_t'(free_ok);
        end
        live = '0;
        for (int s = 0; s < CKPT_DEPTH; s++) begin
            live[s] = (ptr_t'(s) - head_q) <= count_q;
        end
    end

    // Next snapshot contents: writebacks into live slots, then the branch
    // copy, then the rename (which lands only in the newest slot).
    always_comb begin
        tag_n  = tag_q;
        data_n = data_q;
        for (int r = 1; r < NREG; r++) begin
            for (int s = 0; s < CKPT_DEPTH; s++) begin
                if (live[s]) begin
                    {tag_n[r][s], data_n[r][s]} = apply_wb(tag_q[r][s], data_q[r][s],
                                                           bus.wb_en, bus.wb_tag, bus.wb_data);
                end
            end
            if (!bus.br_mis) begin
                if (push_ok) begin
                    tag_n[r][active_nxt]  = tag_n[r][active];
                    data_n[r][active_nxt] = data_n[r][active];
                end
                if (ren_hit && (bus.ren_name == NAME_W'(r))) begin
                    tag_n[r][ren_slot] = bus.ren_tag;
                end
            end
        end
    end

    // Read ports: active snapshot bypassed with same-cycle writebacks.
    always_comb begin
        rd_data_c = '0;
        rd_tag_c  = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [NAME_W-1:0] nm;
            logic [TAG_W+DATA_W-1:0] ent;
            nm = bus.rd_name[p*NAME_W +: NAME_W];
            if (nm == '0) begin
                ent = {TAG_FREE, {DATA_W{1'b0}}};
            end else begin
                ent = apply_wb(tag_q[nm][active], data_q[nm][active],
                               bus.wb_en, bus.wb_tag, bus.wb_data);
            end
            rd_tag_c[p*TAG_W +: TAG_W]   = ent[TAG_W+DATA_W-1 -: TAG_W];
            rd_data_c[p*DATA_W +: DATA_W] = ent[DATA_W-1:0];
        end
    end

    // State registers; rdy low freezes everything, rst wins over rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q   <= '{default: '{default: TAG_FREE}};
            data_q  <= '{default: '{default: '0}};
            head_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (bus.rdy) begin
            tag_q   <= tag_n;
            data_q  <= data_n;
            head_q  <= head_n;
            count_q <= count_n;
            full_q  <= (count_n == ptr_t'(CKPT_DEPTH - 1));
            empty_q <= (count_n == '0);
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.rd_tag     = rd_tag_c;
    assign bus.ckpt_count = count_q;
    assign bus.ckpt_full  = full_q;
    assign bus.ckpt_empty = empty_q;
endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Directed bench for rename_regfile_ckpt. Stimulus pushes expected read and
// checkpoint values into a queue tagged with the cycle they belong to; a
// monitor on the falling edge pops and compares them.
module tb_rename_regfile_ckpt;
    localparam int NAME_W = 5;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam logic [TAG_W-1:0] TF = 4'hF;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sbq[$];

    rename_regfile_ckpt_if #(.NAME_W(NAME_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                             .CKPT_DEPTH(4), .NWB(2), .NRD(2)) bus ();

    rename_regfile_ckpt #(.NREG(32), .NAME_W(NAME_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
                          .CKPT_DEPTH(4), .NWB(2), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index shared by stimulus (after posedge) and monitor (negedge).
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that belongs to the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            case (e.kind)
                0: act = bus.rd_data[e.idx*DATA_W +: DATA_W];
                1: act = 32'(bus.rd_tag[e.idx*TAG_W +: TAG_W]);
                2: act = 32'(bus.ckpt_count);
                3: act = 32'(bus.ckpt_full);
                default: act = 32'(bus.ckpt_empty);
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s (kind %0d port %0d): got %0h expected %0h", e.nm, e.kind, e.idx, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.rdy      = 1'b1;
        bus.wb_en    = '0;
        bus.wb_tag   = '0;
        bus.wb_data  = '0;
        bus.rd_name  = '0;
        bus.ren_en   = 1'b0;
        bus.ren_name = '0;
        bus.ren_tag  = '0;
        bus.br_push  = 1'b0;
        bus.br_free  = 1'b0;
        bus.br_mis   = 1'b0;
    endtask

    task automatic wb(input int p, input logic [TAG_W-1:0] t, input logic [31:0] d);
        bus.wb_en[p] = 1'b1;
        bus.wb_tag[p*TAG_W +: TAG_W] = t;
        bus.wb_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic ren(input logic [NAME_W-1:0] n, input logic [TAG_W-1:0] t);
        bus.ren_en   = 1'b1;
        bus.ren_name = n;
        bus.ren_tag  = t;
    endtask

    task automatic rd(input int p, input logic [NAME_W-1:0] n);
        bus.rd_name[p*NAME_W +: NAME_W] = n;
    endtask

    task automatic push_exp(input int kind, input int idx, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.idx  = idx;
        e.val  = v;
        e.nm   = nm;
        sbq.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] d, input logic [TAG_W-1:0] t, input string nm);
        push_exp(0, p, d, {nm, "_data"});
        push_exp(1, p, 32'(t), {nm, "_tag"});
    endtask

    task automatic exp_ck(input int cnt, input bit full, input bit empty, input string nm);
        push_exp(2, 0, 32'(cnt), {nm, "_count"});
        push_exp(3, 0, 32'(full), {nm, "_full"});
        push_exp(4, 0, 32'(empty), {nm, "_empty"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b0; bus.wb_en = '0; bus.wb_tag = '0; bus.wb_data = '0;
        bus.rd_name = '0; bus.ren_en = 1'b0; bus.ren_name = '0; bus.ren_tag = '0;
        bus.br_push = 1'b0; bus.br_free = 1'b0; bus.br_mis = 1'b0;

        step(); rst = 1'b1;
        step(); rst = 1'b1;

        // Reset values
        step(); rd(0, 5); rd(1, 0);
        exp_rd(0, 0, TF, "rst_r5"); exp_rd(1, 0, TF, "rst_r0"); exp_ck(0, 0, 1, "rst_ckpt");

        // Rename then writeback with bypass
        step(); ren(3, 2); rd(0, 3); exp_rd(0, 0, TF, "ren_not_bypassed");
        step(); wb(1, 2, 32'hAB); rd(0, 3); exp_rd(0, 32'hAB, TF, "wb_bypass");
        step(); rd(0, 3); exp_rd(0, 32'hAB, TF, "wb_persist");

        // Push with same-cycle rename, then mispredict
        step(); ren(3, 1);
        step(); bus.br_push = 1'b1; ren(3, 4); rd(0, 3); exp_rd(0, 32'hAB, 4'd1, "pre_push_r3");
        step(); bus.br_mis = 1'b1; bus.br_push = 1'b1; ren(5, 9); rd(0, 3);
        exp_rd(0, 32'hAB, 4'd4, "push_ren_new"); exp_ck(1, 0, 0, "push_count");
        step(); rd(0, 3); rd(1, 5);
        exp_rd(0, 32'hAB, 4'd1, "mis_restore"); exp_rd(1, 0, TF, "mis_ren_ignored");
        exp_ck(0, 0, 1, "mis_ckpt");
        step(); wb(0, 1, 32'd7); rd(0, 3); exp_rd(0, 32'd7, TF, "wb_after_mis");
        step(); rd(0, 3); exp_rd(0, 32'd7, TF, "wb_after_mis_persist");

        // Fill to full, ignored push (rename still lands), drain with wrap
        step(); bus.br_push = 1'b1; exp_ck(0, 0, 1, "fill0");
        step(); bus.br_push = 1'b1; exp_ck(1, 0, 0, "fill1");
        step(); bus.br_push = 1'b1; exp_ck(2, 0, 0, "fill2");
        step(); bus.br_push = 1'b1; ren(7, 4'hA); exp_ck(3, 1, 0, "full");
        step(); bus.br_free = 1'b1; exp_ck(3, 1, 0, "push_when_full");
        step(); bus.br_free = 1'b1; exp_ck(2, 0, 0, "drain2");
        step(); bus.br_free = 1'b1; exp_ck(1, 0, 0, "drain1");
        step(); bus.br_free = 1'b1; exp_ck(0, 0, 1, "free_to_empty");
        step(); rd(0, 7); exp_rd(0, 0, 4'hA, "ren_when_full"); exp_ck(0, 0, 1, "free_empty_ignored");

        // Writeback updates both snapshots before mispredict (wrapped slots)
        step(); ren(2, 5);
        step(); bus.br_push = 1'b1; rd(0, 2); exp_rd(0, 0, 4'd5, "r2_renamed");
        step(); wb(0, 5, 32'd9); rd(0, 2); exp_rd(0, 32'd9, TF, "r2_wb_bypass");
        exp_ck(1, 0, 0, "wrap_push");
        step(); bus.br_mis = 1'b1; rd(0, 2); exp_rd(0, 32'd9, TF, "r2_pre_mis");
        step(); rd(0, 2); rd(1, 7);
        exp_rd(0, 32'd9, TF, "r2_restored_wb"); exp_rd(1, 0, 4'hA, "r7_restored");
        exp_ck(0, 0, 1, "mis2_ckpt");

        // Port priority and TAG_FREE writeback ignored
        step(); ren(4, 6);
        step(); wb(0, 6, 32'h11); wb(1, 6, 32'h22); rd(0, 4); exp_rd(0, 32'h11, TF, "wb_port_prio");
        step(); wb(0, TF, 32'h55); rd(0, 4); rd(1, 0);
        exp_rd(0, 32'h11, TF, "wb_free_ignored"); exp_rd(1, 0, TF, "r0_zero");

        // Push+free at count 2, rdy hold, reset mid-operation
        step(); bus.br_push = 1'b1;
        step(); bus.br_push = 1'b1; exp_ck(1, 0, 0, "pf1");
        step(); bus.br_push = 1'b1; bus.br_free = 1'b1; exp_ck(2, 0, 0, "pf2");
        step(); ren(5, 3); exp_ck(2, 0, 0, "push_free_same");
        step(); bus.rdy = 1'b0; wb(0, 3, 32'h33); ren(6, 8); bus.br_push = 1'b1;
        step(); rd(0, 5); rd(1, 6);
        exp_rd(0, 0, 4'd3, "rdy_hold_r5"); exp_rd(1, 0, TF, "rdy_hold_r6");
        exp_ck(2, 0, 0, "rdy_hold_ckpt");
        step(); rst = 1'b1; bus.rdy = 1'b0; wb(0, 3, 32'h44);
        step(); rd(0, 3); rd(1, 5);
        exp_rd(0, 0, TF, "rst_r3"); exp_rd(1, 0, TF, "rst_r5"); exp_ck(0, 0, 1, "rst_mid_ckpt");

        step();
        step();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rename_regfile_ckpt.md
# rename_regfile_ckpt

Parametrised renaming register file with per-register branch checkpoint rings and N writeback ports, sitting between the decoder/dispatcher and the reservation stations. Each architectural register holds either committed-ready data or the tag of its pending producer. The block keeps up to CKPT_DEPTH-1 outstanding-branch snapshots. Writebacks update every live snapshot. A mispredict of the oldest branch restores its snapshot in one cycle.

## Interface
- NREG, 32: architectural registers; register 0 is hard-wired zero.
- NAME_W, 5: register name width, clog2(NREG).
- DATA_W, 32: data width.
- TAG_W, 4: tag width; TAG_FREE = all ones means "value ready".
- CKPT_DEPTH, 4: snapshots per register; power of two, ≥2; max outstanding branches = CKPT_DEPTH-1.
- NWB, 2: writeback ports (ALU, LS, …).
- NRD, 2: read ports.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low holds all state.
- wb_en  in  NWB  per-port writeback valid.
- wb_tag  in  NWB*TAG_W  writeback tags, port k at [k*TAG_W +: TAG_W].
- wb_data  in  NWB*DATA_W  writeback data.
- rd_name  in  NRD*NAME_W  read register names.
- rd_data  out  NRD*DATA_W  read data.
- rd_tag  out  NRD*TAG_W  read tags; TAG_FREE means rd_data valid.
- ren_en  in  1  rename request.
- ren_name  in  NAME_W  destination register.
- ren_tag  in  TAG_W  new producer tag.
- br_push  in  1  branch dispatched: open new snapshot.
- br_free  in  1  oldest branch resolved correct: release its snapshot.
- br_mis  in  1  oldest branch mispredicted: restore its snapshot.
- ckpt_count  out  clog2(CKPT_DEPTH)  outstanding branches.
- ckpt_full  out  1  ckpt_count == CKPT_DEPTH-1.
- ckpt_empty  out  1  ckpt_count == 0.

## Operation
- State per register: tag[CKPT_DEPTH] and data[CKPT_DEPTH]. Shared pointers: head, active = head+count (mod CKPT_DEPTH), and count.
- Writeback: every live snapshot (head..active) whose tag equals wb_tag[k] with wb_en[k] set takes data=wb_data[k], tag=TAG_FREE. wb_tag == TAG_FREE is ignored. If several ports match, the lowest k wins.
- Rename: when ren_en is set and ren_name≠0, the active snapshot tag of ren_name becomes ren_tag. Data is unchanged. This overrides a same-cycle writeback to that entry; other snapshots still take the writeback.
- br_push, when not full: snapshot active+1 becomes a copy of active after this cycle's writebacks. A same-cycle rename applies only to the new snapshot; the old snapshot gets no rename. count+1.
- br_push when full: ignored; rename still applies to the current active snapshot.
- br_free with count>0: head+1 and count-1. br_free with count==0 is ignored. br_free together with br_push: count unchanged, and both pointer moves happen.
- br_mis: count becomes 0, so active = head. The head snapshot plus this cycle's writebacks becomes current. br_mis has priority over br_push, br_free and ren_en, which are all ignored that cycle.
- Reads (combinational) come from the pre-edge active snapshot, bypassed with this cycle's matching writebacks. Same-cycle rename is not bypassed. rd_name==0 returns data 0 and TAG_FREE.
- Reset: all tags TAG_FREE, all data 0, head=0, count=0, ckpt_empty=1, ckpt_full=0, ckpt_count=0.

## Timing
- Reads have zero latency. A writeback is visible on rd_* in the same cycle. A rename is visible from the next cycle.
- All state updates at posedge clk, and only when rdy=1 and rst=0. rst overrides rdy.
- ckpt_* outputs are registered and reflect the pointers after the last edge.
- A restore after br_mis takes effect at the next edge. The first post-restore read is in the following cycle.
- Pointers wrap modulo CKPT_DEPTH. count never exceeds CKPT_DEPTH-1, so the active snapshot never overwrites head.

## Test plan
- Reset, then read r5 and r0 → data 0, tag TAG_FREE. ckpt_empty=1.
- Rename r3 to tag 2, then on the next cycle wb port1 tag 2 data 0xAB → in the wb cycle rd r3 gives 0xAB/TAG_FREE via bypass; it persists afterwards.
- Rename r3 to tag 1; br_push plus rename r3 to tag 4 in the same cycle; br_mis → r3 tag reads 1. Then wb tag 1 data 7 → r3=7.
- Push 3 branches (CKPT_DEPTH=4) → ckpt_full=1; a 4th push is ignored, count stays 3. Free 3 → empty; pointers have wrapped.
- Rename r2 to tag 5, push, then wb tag 5 data 9, then br_mis → r2 = 9, TAG_FREE, because the writeback updated both snapshots.
- br_free with br_push at count 2 → count stays 2. Hold rdy=0 with wb_en → no state change. rst mid-operation → all reset values next cycle.
